dac_sample_sequencer: RTL

//  Paces 4-bit sample codes into the R-2R DAC at a programmable sample rate.

---
 rtl/dac_seq_pkg.sv | 13 +
 rtl/dac_seq_fifo.sv | 79 +++++++
 rtl/dac_sample_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dac_seq_pkg.sv
// rtl/dac_seq_pkg.sv - shared types and defaults for the DAC sample sequencer
package dac_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int CODE_W_DEF = 4;
    localparam int DEPTH_DEF  = 8;
    localparam int DIV_W_DEF  = 8;

endpackage

// File: rtl/dac_seq_fifo.sv
// rtl/dac_seq_fifo.sv - code FIFO with flush and a random-access peek port
import dac_seq_pkg::*;

module dac_seq_fifo #(
    parameter int CODE_W = CODE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [CODE_W-1:0]          push_data,
    input  logic                       pop,
    input  logic [$clog2(DEPTH)-1:0]   peek_addr,
    output logic [CODE_W-1:0]          peek_data,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push_en, pop_en;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign rd_ptr    = rd_ptr_q;
    assign peek_data = mem_q[peek_addr];

    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + LVL_W'(push_en) - LVL_W'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/dac_sample_sequencer.sv
// rtl/dac_sample_sequencer.sv - paces queued codes onto the DAC at div+1 cycle intervals
// Optional loop playback input enabled by defining DAC_SEQ_LOOP_EN.
import dac_seq_pkg::*;

module dac_sample_sequencer #(
    parameter int CODE_W = CODE_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef DAC_SEQ_LOOP_EN
    input  logic                     loop,
`endif
    input  logic                     wr_valid,
    input  logic [CODE_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     flush,
    input  logic [DIV_W-1:0]         div,
    output logic [CODE_W-1:0]        dac_code,
    output logic                     dac_update,
    output logic                     busy,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [CODE_W-1:0] dac_code_q, dac_code_d;
    logic              dac_update_q, dac_update_d;
    logic              underrun_q, underrun_d;
    logic [PTR_W-1:0]  play_ptr_q, play_ptr_d;
    logic              loop_q, loop_d;

    logic              loop_w;
    logic              run, tick, loop_act, loop_rise, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [PTR_W-1:0]  rd_ptr, peek_addr, eff_play, play_next, play_offs;
    logic [CODE_W-1:0] peek_data;
    logic [LVL_W-1:0]  fifo_level;

`ifdef DAC_SEQ_LOOP_EN
    assign loop_w = loop;
`else
    assign loop_w = 1'b0;
`endif

    dac_seq_fifo #(
        .CODE_W (CODE_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (wr_valid),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .peek_addr (peek_addr),
        .peek_data (peek_data),
        .rd_ptr    (rd_ptr),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (stop)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run  = (state_q == ST_RUN);
        busy = run;
    end

    // Stop wins over a tick landing in the same cycle.
    assign tick      = run && !stop && (presc_q == div);
    assign loop_act  = loop_w && run;
    assign loop_rise = loop_w && !loop_q;
    assign eff_play  = loop_rise ? rd_ptr : play_ptr_q;
    assign peek_addr = loop_act ? eff_play : rd_ptr;

    // Play pointer cycles over the stored entries only, restarting at the head.
    always_comb begin
        play_next = eff_play + 1'b1;
        play_offs = play_next - rd_ptr;
        if ({1'b0, play_offs} >= fifo_level) begin
            play_next = rd_ptr;
        end
    end

    always_comb begin
        presc_d      = '0;
        dac_code_d   = dac_code_q;
        dac_update_d = 1'b0;
        underrun_d   = underrun_q;
        play_ptr_d   = loop_act ? eff_play : rd_ptr;
        loop_d       = loop_w;
        fifo_pop     = 1'b0;

        if (run && !stop) begin
            presc_d = (presc_q == div) ? '0 : presc_q + 1'b1;
        end

        if (flush) begin
            underrun_d = 1'b0;
            play_ptr_d = '0;
        end else if (tick) begin
            if (!fifo_empty) begin
                dac_code_d   = peek_data;
                dac_update_d = 1'b1;
                fifo_pop     = !loop_act;
                if (loop_act) begin
                    play_ptr_d = play_next;
                end
            end else begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            dac_code_q   <= '0;
            dac_update_q <= 1'b0;
            underrun_q   <= 1'b0;
            play_ptr_q   <= '0;
            loop_q       <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            dac_code_q   <= dac_code_d;
            dac_update_q <= dac_update_d;
            underrun_q   <= underrun_d;
            play_ptr_q   <= play_ptr_d;
            loop_q       <= loop_d;
        end
    end

    assign wr_ready   = !fifo_full;
    assign dac_code   = dac_code_q;
    assign dac_update = dac_update_q;
    assign underrun   = underrun_q;
    assign level      = fifo_level;

endmodule
